fetch_queue: RTL

Parametrised instruction-fetch front end for the pipelined core. It replaces the single-PC, single-cycle fetch stage with a decoupled prefetcher. The prefetcher issues in-order requests to an instruction memory with variable latency, buffers up to DEPTH instructions together with their PCs, and hands them to the IF/ID register through a valid/ready handshake. Redirects from jump, jr or taken-branch resolution flush the queue and discard stale in-flight responses.

---
 rtl/fetch_queue.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Decoupled instruction prefetcher: issues in-order requests to a variable-latency
// instruction memory, buffers up to DEPTH {pc, inst} entries and presents the head
// to decode over a valid/ready handshake. A redirect flushes the queue and discards
// every response still owed to the old fetch stream.
module fetch_queue #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pc_add4
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned PtrW = IdxW + 1;
  localparam logic [PtrW-1:0] DepthP = PtrW'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0]   alloc_ptr_q, alloc_ptr_d;
  logic [PtrW-1:0]   fill_ptr_q, fill_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   outst_q, outst_d;
  logic [PtrW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [ADDR_W-1:0] slot_pc_q [DEPTH];
  logic [ADDR_W-1:0] slot_pc_d [DEPTH];
  logic [INST_W-1:0] slot_inst_q [DEPTH];
  logic [INST_W-1:0] slot_inst_d [DEPTH];
  logic [DEPTH-1:0]  slot_filled_q, slot_filled_d;

  logic [IdxW-1:0] alloc_idx, fill_idx, rd_idx;
  logic [PtrW-1:0] occupancy;
  logic            grant, pop;

  assign alloc_idx = alloc_ptr_q[IdxW-1:0];
  assign fill_idx  = fill_ptr_q[IdxW-1:0];
  assign rd_idx    = rd_ptr_q[IdxW-1:0];
  assign occupancy = alloc_ptr_q - rd_ptr_q;

  // Issue and head presentation, combinational from registered state
  always_comb begin
    imem_req    = ~redirect & (occupancy < DepthP) & (outst_q < DepthP);
    imem_addr   = fetch_pc_q;
    grant       = imem_req & imem_gnt;
    out_valid   = slot_filled_q[rd_idx] & ~redirect;
    pop         = out_valid & out_ready;
    out_inst    = slot_inst_q[rd_idx];
    out_pc      = slot_pc_q[rd_idx];
    out_pc_add4 = slot_pc_q[rd_idx] + ADDR_W'(4);
  end

  // Next-state: redirect flushes everything, otherwise allocate / fill / pop
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    alloc_ptr_d   = alloc_ptr_q;
    fill_ptr_d    = fill_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    outst_d       = outst_q;
    drop_cnt_d    = drop_cnt_q;
    slot_pc_d     = slot_pc_q;
    slot_inst_d   = slot_inst_q;
    slot_filled_d = slot_filled_q;
    if (redirect) begin
      alloc_ptr_d   = '0;
      fill_ptr_d    = '0;
      rd_ptr_d      = '0;
      slot_filled_d = '0;
      fetch_pc_d    = {redirect_pc[ADDR_W-1:2], 2'b00};
      // A response arriving now is consumed (and dropped) this cycle
      drop_cnt_d    = outst_q - PtrW'(imem_rvalid);
      outst_d       = outst_q - PtrW'(imem_rvalid);
    end else begin
      if (grant) begin
        slot_pc_d[alloc_idx]     = fetch_pc_q;
        slot_filled_d[alloc_idx] = 1'b0;
        alloc_ptr_d              = alloc_ptr_q + PtrW'(1);
        fetch_pc_d               = fetch_pc_q + ADDR_W'(4);
      end
      if (imem_rvalid) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - PtrW'(1);
        end else begin
          slot_inst_d[fill_idx]   = imem_rdata;
          slot_filled_d[fill_idx] = 1'b1;
          fill_ptr_d              = fill_ptr_q + PtrW'(1);
        end
      end
      // Clear on pop so an empty queue never shows a stale filled slot at the head
      if (pop) begin
        slot_filled_d[rd_idx] = 1'b0;
        rd_ptr_d              = rd_ptr_q + PtrW'(1);
      end
      outst_d = outst_q + PtrW'(grant) - PtrW'(imem_rvalid);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      alloc_ptr_q   <= '0;
      fill_ptr_q    <= '0;
      rd_ptr_q      <= '0;
      outst_q       <= '0;
      drop_cnt_q    <= '0;
      slot_pc_q     <= '{default: '0};
      slot_inst_q   <= '{default: '0};
      slot_filled_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      alloc_ptr_q   <= alloc_ptr_d;
      fill_ptr_q    <= fill_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      outst_q       <= outst_d;
      drop_cnt_q    <= drop_cnt_d;
      slot_pc_q     <= slot_pc_d;
      slot_inst_q   <= slot_inst_d;
      slot_filled_q <= slot_filled_d;
    end
  end

  // A response with nothing outstanding is a memory protocol violation
  rsp_without_req: assert property (@(posedge clk) disable iff (reset)
    !(imem_rvalid && (outst_q == '0)));

endmodule
